// File: rtl/camera_stream_capture.sv
// DVP camera capture front end: packs camera bytes into pixels, optionally decimates,
// and frames each image with control tokens into a downstream write queue.
`timescale 1ns/1ps

// state      | meaning
// IDLE       | waiting for init_done and vertical blank
// WAIT_FRAME | in blank; the falling edge of VSYNC starts a frame
// WAIT_HREF  | between lines; VSYNC here aborts the frame
// CAPTURE    | HREF high, sampling bytes into pixels
// ROW_DONE   | line finished, length check and row advance
// TERMINATE  | holding the terminal token until the queue accepts it
module camera_stream_capture #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int BYTE_ORDER      = 0,
  parameter int DECIM           = 1
) (
  input  logic        PixelClk,
  input  logic        nRST,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  p_data,
  input  logic        init_done,
  input  logic        queue_full,
  output logic        queue_clk,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic        line_err
);

  localparam int LINE_BYTES = FRAME_WIDTH * BYTES_PER_PIXEL;
  localparam int BW         = $clog2(LINE_BYTES + 2);
  localparam int RW_RAW     = $clog2(FRAME_HEIGHT + 1);
  localparam int RW         = (RW_RAW < 2) ? 2 : RW_RAW;
  localparam int CW_RAW     = $clog2(FRAME_WIDTH + 1);
  localparam int CW         = (CW_RAW < 2) ? 2 : CW_RAW;

  localparam logic [BW-1:0] LINE_LEN = BW'(LINE_BYTES);
  localparam logic [BW-1:0] BYTE_SAT = BW'(LINE_BYTES + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(FRAME_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LIM  = RW'(FRAME_HEIGHT);
  localparam logic [1:0]    DMASK    = 2'(DECIM - 1);

  localparam logic [16:0] TOK_FRAME_START = 17'h10000;
  localparam logic [16:0] TOK_ROW_START   = 17'h10001;
  localparam logic [16:0] TOK_FRAME_END   = 17'h1FFFF;
  localparam logic [16:0] TOK_FRAME_ABORT = 17'h1FFFE;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    WAIT_HREF,
    CAPTURE,
    ROW_DONE,
    TERMINATE
  } state_t;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [BW-1:0]   byte_cnt;
  logic [7:0]      first_byte;
  logic            phase;
  logic            pix_vld;
  logic            pix_keep;
  logic [15:0]     pix_data;
  logic            term_end;

  logic            row_keep;
  logic            col_keep;
  logic [15:0]     pix_next;

  assign queue_clk = PixelClk;
  assign row_keep  = (row[1:0] & DMASK) == 2'b00;
  assign col_keep  = (col[1:0] & DMASK) == 2'b00;

  always_comb begin
    pix_next = 16'h0000;
    if (BYTES_PER_PIXEL == 1)
      pix_next = {8'h00, p_data};
    else if (BYTE_ORDER == 0)
      pix_next = {first_byte, p_data};
    else
      pix_next = {p_data, first_byte};
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      byte_cnt    <= '0;
      first_byte  <= 8'h00;
      phase       <= 1'b0;
      pix_vld     <= 1'b0;
      pix_keep    <= 1'b0;
      pix_data    <= 16'h0000;
      term_end    <= 1'b0;
      queue_data  <= 17'h00000;
      queue_wr_en <= 1'b0;
      frame_count <= 16'h0000;
      overflow    <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      queue_wr_en <= 1'b0;
      line_err    <= 1'b0;
      pix_vld     <= 1'b0;

      // Pixel assembled last cycle goes out now; it never collides with a token.
      if (pix_vld && pix_keep) begin
        queue_data <= {1'b0, pix_data};
        if (queue_full)
          overflow <= 1'b1;
        else
          queue_wr_en <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (init_done && cam_vsync)
            state <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          if (!cam_vsync) begin
            queue_data  <= TOK_FRAME_START;
            queue_wr_en <= !queue_full;
            overflow    <= queue_full;
            row         <= '0;
            state       <= WAIT_HREF;
          end
        end

        WAIT_HREF: begin
          if (cam_vsync && (row < ROW_LIM)) begin
            term_end <= 1'b0;
            state    <= TERMINATE;
          end else if (cam_href) begin
            byte_cnt <= BW'(1);
            phase    <= 1'b0;
            if (row_keep) begin
              queue_data <= TOK_ROW_START;
              if (queue_full)
                overflow <= 1'b1;
              else
                queue_wr_en <= 1'b1;
            end
            if (BYTES_PER_PIXEL == 1) begin
              pix_vld  <= 1'b1;
              pix_data <= pix_next;
              pix_keep <= row_keep;
              col      <= CW'(1);
            end else begin
              first_byte <= p_data;
              phase      <= 1'b1;
              col        <= '0;
            end
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (cam_href) begin
            if (byte_cnt != BYTE_SAT)
              byte_cnt <= byte_cnt + BW'(1);
            if ((BYTES_PER_PIXEL == 1) || phase) begin
              pix_vld  <= 1'b1;
              pix_data <= pix_next;
              pix_keep <= row_keep && col_keep;
              col      <= col + CW'(1);
              phase    <= 1'b0;
            end else begin
              first_byte <= p_data;
              phase      <= 1'b1;
            end
          end else begin
            state <= ROW_DONE;
          end
        end

        ROW_DONE: begin
          if (byte_cnt != LINE_LEN) begin
            line_err <= 1'b1;
            term_end <= 1'b0;
            state    <= TERMINATE;
          end else begin
            row <= row + RW'(1);
            if (row == LAST_ROW) begin
              term_end <= 1'b1;
              state    <= TERMINATE;
            end else begin
              state <= WAIT_HREF;
            end
          end
        end

        TERMINATE: begin
          // Only the terminal token waits out back-pressure; everything else is dropped.
          queue_data <= (term_end && !overflow) ? TOK_FRAME_END : TOK_FRAME_ABORT;
          if (!queue_full) begin
            queue_wr_en <= 1'b1;
            if (term_end && !overflow)
              frame_count <= frame_count + 16'd1;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
